// File: rtl/asa_pu_tx_pkg.sv
// Shared constants and FSM state type for the per-PU RAS message transmitter.
package asa_pu_tx_pkg;

    localparam int NUM_OF_PU      = 4;
    localparam int PU_ASA_NBITS   = 32;
    localparam int PU_ID_NBITS    = 2;
    localparam int PU_ASA_TS      = 6;
    localparam int WORD_CNT_NBITS = 8;

    typedef enum logic [1:0] {
        ASA_TX_IDLE = 2'd0,
        ASA_TX_SEND = 2'd1,
        ASA_TX_GAP  = 2'd2
    } asa_tx_state_e;

endpackage

// File: rtl/asa_pu_tx_fifo.sv
// Per-PU show-ahead word FIFO with occupancy count and a registered full flag.
module asa_pu_tx_fifo
    import asa_pu_tx_pkg::*;
#(
    parameter int W           = PU_ASA_NBITS + 1,
    parameter int DEPTH_NBITS = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [DEPTH_NBITS:0]   count_o,
    output logic                   full_o
);

    localparam int                 DEPTH     = 1 << DEPTH_NBITS;
    localparam logic [DEPTH_NBITS:0] DEPTH_CNT = (DEPTH_NBITS + 1)'(DEPTH);

    logic [W-1:0]             mem_q [DEPTH];
    logic [DEPTH_NBITS-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_NBITS:0]     count_q, count_d;
    logic                     full_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)
            count_d = count_q + 1'b1;
        else if (!push_i && pop_i)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/asa_pu_tx.sv
// Round-robin serializer of complete per-PU RAS messages onto the pu_asa word stream;
// bursts are contiguous and never interleave.
module asa_pu_tx
    import asa_pu_tx_pkg::*;
#(
    parameter int NUM_PU      = NUM_OF_PU,
    parameter int DEPTH_NBITS = 3,
    parameter int IFG         = 0
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_PU-1:0]                pu_wr,
    input  logic [NUM_PU*PU_ASA_NBITS-1:0]   pu_wdata,
    input  logic [NUM_PU-1:0]                pu_weop,
    output logic [NUM_PU-1:0]                pu_full,
    output logic                             pu_asa_start,
    output logic                             pu_asa_valid,
    output logic [PU_ASA_NBITS-1:0]          pu_asa_data,
    output logic                             pu_asa_eop,
    output logic [PU_ID_NBITS-1:0]           pu_asa_pu_id,
    output logic                             len_err,
    output logic [NUM_PU-1:0]                ovf_err
);

    localparam int GAP_NBITS = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [PU_ID_NBITS-1:0] LAST_RST = PU_ID_NBITS'(NUM_PU - 1);

    function automatic logic [PU_ID_NBITS-1:0] rr_pick(input logic [NUM_PU-1:0] req,
                                                       input logic [PU_ID_NBITS-1:0] last);
        logic [PU_ID_NBITS-1:0] pick;
        int idx;
        pick = last;
        // Walk offsets from farthest to nearest so the nearest requester after last wins.
        for (int off = NUM_PU; off >= 1; off--) begin
            idx = (int'(last) + off) % NUM_PU;
            if (req[idx]) pick = PU_ID_NBITS'(idx);
        end
        return pick;
    endfunction

    logic [NUM_PU-1:0]          fifo_push, fifo_pop, fifo_full, eligible;
    logic [PU_ASA_NBITS:0]      fifo_rdata [NUM_PU];
    logic [DEPTH_NBITS:0]       fifo_count [NUM_PU];
    logic [DEPTH_NBITS:0]       msg_cnt_q  [NUM_PU];

    for (genvar i = 0; i < NUM_PU; i++) begin : g_pu
        assign fifo_push[i] = pu_wr[i] & ~fifo_full[i];
        assign eligible[i]  = (msg_cnt_q[i] != '0) | fifo_full[i];

        asa_pu_tx_fifo #(
            .W           (PU_ASA_NBITS + 1),
            .DEPTH_NBITS (DEPTH_NBITS)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .push_i  (fifo_push[i]),
            .wdata_i ({pu_weop[i], pu_wdata[i*PU_ASA_NBITS +: PU_ASA_NBITS]}),
            .pop_i   (fifo_pop[i]),
            .rdata_o (fifo_rdata[i]),
            .count_o (fifo_count[i]),
            .full_o  (fifo_full[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_PU; i++) msg_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PU; i++) begin
                if ((fifo_push[i] & pu_weop[i]) && !(fifo_pop[i] & fifo_rdata[i][PU_ASA_NBITS]))
                    msg_cnt_q[i] <= msg_cnt_q[i] + 1'b1;
                else if (!(fifo_push[i] & pu_weop[i]) && (fifo_pop[i] & fifo_rdata[i][PU_ASA_NBITS]))
                    msg_cnt_q[i] <= msg_cnt_q[i] - 1'b1;
            end
        end
    end

    asa_tx_state_e               state_q, state_d;
    logic [PU_ID_NBITS-1:0]      grant_q, grant_d, last_q, last_d, sel;
    logic [GAP_NBITS-1:0]        gap_q, gap_d;
    logic [WORD_CNT_NBITS-1:0]   word_cnt_q, word_cnt_d;
    logic                        emit, word_eop;
    logic [PU_ASA_NBITS:0]       head;
    logic                        start_q, start_d, valid_q, valid_d, eop_q, eop_d, len_q, len_d;
    logic [PU_ASA_NBITS-1:0]     data_q, data_d;
    logic [PU_ID_NBITS-1:0]      id_q, id_d;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        gap_d      = gap_q;
        word_cnt_d = word_cnt_q;
        emit       = 1'b0;
        start_d    = 1'b0;

        sel  = (state_q == ASA_TX_IDLE) ? rr_pick(eligible, last_q) : grant_q;
        head = fifo_rdata[sel];
        // With no complete message queued, the last stored word closes the burst.
        word_eop = head[PU_ASA_NBITS] |
                   ((msg_cnt_q[sel] == '0) && (fifo_count[sel] == (DEPTH_NBITS + 1)'(1)));

        unique case (state_q)
            ASA_TX_IDLE: begin
                if (|eligible) begin
                    emit       = 1'b1;
                    start_d    = 1'b1;
                    grant_d    = sel;
                    last_d     = sel;
                    word_cnt_d = WORD_CNT_NBITS'(1);
                    state_d    = ASA_TX_SEND;
                end
            end
            ASA_TX_SEND: begin
                if (eop_q) begin
                    gap_d   = '0;
                    state_d = (IFG > 0) ? ASA_TX_GAP : ASA_TX_IDLE;
                end else begin
                    emit       = 1'b1;
                    word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;
                end
            end
            ASA_TX_GAP: begin
                if (gap_q == GAP_NBITS'(IFG - 1)) state_d = ASA_TX_IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = ASA_TX_IDLE;
        endcase

        fifo_pop = emit ? (NUM_PU'(1) << sel) : '0;
        valid_d  = emit;
        eop_d    = emit & word_eop;
        len_d    = emit & word_eop & (word_cnt_d != WORD_CNT_NBITS'(PU_ASA_TS));
        data_d   = emit ? head[PU_ASA_NBITS-1:0] : '0;
        id_d     = emit ? sel : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ASA_TX_IDLE;
            grant_q    <= '0;
            last_q     <= LAST_RST;
            gap_q      <= '0;
            word_cnt_q <= '0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            eop_q      <= 1'b0;
            len_q      <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            word_cnt_q <= word_cnt_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            eop_q      <= eop_d;
            len_q      <= len_d;
            data_q     <= data_d;
            id_q       <= id_d;
        end
    end

    assign pu_full      = fifo_full;
    assign ovf_err      = pu_wr & fifo_full;
    assign pu_asa_start = start_q;
    assign pu_asa_valid = valid_q;
    assign pu_asa_data  = data_q;
    assign pu_asa_eop   = eop_q;
    assign pu_asa_pu_id = id_q;
    assign len_err      = len_q;

endmodule
